// File: rtl/width_pack_16to128.sv
// Gathers narrow IN_WIDTH words into OUT_WIDTH words with a lane-keep mask; in_last flushes a partial word.
// Optional transfer statistics (stat_words, stat_partial) are enabled by defining WIDTH_PACK_STATS_EN.
module width_pack_16to128 #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 128,
  parameter int MSB_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          tb_rst,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [OUT_WIDTH/IN_WIDTH-1:0] out_keep,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef WIDTH_PACK_STATS_EN
  output logic [15:0]                   stat_words,
  output logic [15:0]                   stat_partial,
`endif
  output logic [3:0]                    lane_cnt
);

  // state | meaning
  // FILL  | accepting narrow words into the accumulator
  // HOLD  | accumulator complete, waiting for the output stage to drain

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state, state_nxt;
  logic [OUT_WIDTH-1:0] acc, acc_wr;
  logic [3:0]           lane_pos, lane_inc;
  logic                 accept, complete, out_xfer, out_free;

  function automatic logic [RATIO-1:0] keep_of(input logic [3:0] n);
    logic [RATIO-1:0] k;
    for (int i = 0; i < RATIO; i++) k[i] = (4'(i) < n);
    return k;
  endfunction

  assign accept   = in_valid && in_ready;
  assign complete = accept && ((lane_cnt == 4'(RATIO - 1)) || in_last);
  assign out_xfer = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;
  assign lane_inc = lane_cnt + 4'd1;
  assign lane_pos = (MSB_FIRST != 0) ? (4'(RATIO - 1) - lane_cnt) : lane_cnt;

  always_comb begin
    acc_wr = acc;
    for (int i = 0; i < RATIO; i++)
      if (lane_pos == 4'(i)) acc_wr[i*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (complete && !out_free) state_nxt = HOLD;
      HOLD:    if (out_xfer)              state_nxt = FILL;
      default:                            state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = (state == FILL);
  end

  // Output stage is loaded either directly from a completing accept or from the held accumulator.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      acc       <= '0;
      lane_cnt  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_xfer) out_valid <= 1'b0;
      case (state)
        FILL: if (accept) begin
          if (complete && out_free) begin
            out_data  <= acc_wr;
            out_keep  <= keep_of(lane_inc);
            out_valid <= 1'b1;
            acc       <= '0;
            lane_cnt  <= '0;
          end else begin
            acc      <= acc_wr;
            lane_cnt <= lane_inc;
          end
        end
        HOLD: if (out_xfer) begin
          out_data  <= acc;
          out_keep  <= keep_of(lane_cnt);
          out_valid <= 1'b1;
          acc       <= '0;
          lane_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef WIDTH_PACK_STATS_EN
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      stat_words   <= '0;
      stat_partial <= '0;
    end else if (out_xfer) begin
      stat_words <= stat_words + 16'd1;
      if (out_keep != {RATIO{1'b1}}) stat_partial <= stat_partial + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_width_pack_16to128.sv
// Scoreboard bench for width_pack_16to128: a reference packer pushes expected words, a monitor pops on transfer.
// Stat counters are checked only when WIDTH_PACK_STATS_EN is defined.
module tb_width_pack_16to128;

  logic         clk = 1'b0;
  logic         tb_rst;
  logic [15:0]  in_data;
  logic         in_valid, in_last, in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_valid, out_ready;
  logic [3:0]   lane_cnt;

  logic         msb_en;
  logic         in_valid_m, in_ready_m, out_valid_m;
  logic [127:0] out_data_m;
  logic [7:0]   out_keep_m;
  logic [3:0]   lane_cnt_m;
  logic         out_ready_m = 1'b1;
`ifdef WIDTH_PACK_STATS_EN
  logic [15:0]  stat_words, stat_partial, stat_words_m, stat_partial_m;
`endif

  assign in_valid_m = in_valid && msb_en;

  width_pack_16to128 dut (
    .clk(clk), .tb_rst(tb_rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef WIDTH_PACK_STATS_EN
    .stat_words(stat_words), .stat_partial(stat_partial),
`endif
    .lane_cnt(lane_cnt)
  );

  width_pack_16to128 #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .tb_rst(tb_rst), .in_data(in_data), .in_valid(in_valid_m), .in_last(in_last),
    .in_ready(in_ready_m), .out_data(out_data_m), .out_keep(out_keep_m), .out_valid(out_valid_m),
    .out_ready(out_ready_m),
`ifdef WIDTH_PACK_STATS_EN
    .stat_words(stat_words_m), .stat_partial(stat_partial_m),
`endif
    .lane_cnt(lane_cnt_m)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  int stalls = 0;
  logic [135:0] sb_q[$];
  logic [127:0] m_acc;
  int m_n;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference packer: LSB-first placement, keep has the lower n bits set.
  task automatic model_accept(input logic [15:0] d, input logic last);
    logic [7:0] k;
    m_acc[m_n*16 +: 16] = d;
    m_n++;
    if (m_n == 8 || last) begin
      for (int i = 0; i < 8; i++) k[i] = (i < m_n);
      sb_q.push_back({k, m_acc});
      m_acc = '0;
      m_n   = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    logic r;
    int   waits = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      stalls++;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", {127'd0, in_ready}, 128'd1);
        break;
      end
    end
    if (r) begin
      acc_cnt++;
      model_accept(d, last);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard, and check output stability under back-pressure.
  initial begin
    logic         held = 1'b0;
    logic [127:0] held_data;
    logic [7:0]   held_keep;
    logic [135:0] e;
    forever begin
      @(negedge clk);
      if (held && out_valid && !tb_rst) begin
        chk("stable_data", out_data, held_data);
        chk("stable_keep", {120'd0, out_keep}, {120'd0, held_keep});
      end
      held = out_valid && !out_ready && !tb_rst;
      held_data = out_data;
      held_keep = out_keep;
      if (out_valid && out_ready && !tb_rst) begin
        if (sb_q.size() == 0) chk("sb_underflow", 128'd0, 128'd1);
        else begin
          e = sb_q.pop_front();
          chk("sb_data", out_data, e[127:0]);
          chk("sb_keep", {120'd0, out_keep}, {120'd0, e[135:128]});
        end
      end
    end
  end

  initial begin
    tb_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1; msb_en = 1'b0; m_acc = '0; m_n = 0;
    #2;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_keep", {120'd0, out_keep}, 128'd0);
    chk("rst_lanes", {124'd0, lane_cnt}, 128'd0);
    chk("rst_ready", {127'd0, in_ready}, 128'd1);
    #20 tb_rst = 1'b0;
    @(posedge clk); #1;

    // Full word, both fill orders
    msb_en = 1'b1; stalls = 0;
    for (int i = 0; i < 8; i++) send(16'(i), 1'b0);
    in_valid = 1'b0; msb_en = 1'b0;
    @(negedge clk);
    chk("s1_valid", {127'd0, out_valid}, 128'd1);
    chk("s1_data", out_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("s1_keep", {120'd0, out_keep}, 128'hFF);
    chk("s1_stalls", 128'(stalls), 128'd0);
    chk("msb_data", out_data_m, 128'h0000_0001_0002_0003_0004_0005_0006_0007);
    chk("msb_keep", {120'd0, out_keep_m}, 128'hFF);

    // Partial flush
    @(posedge clk); #1;
    send(16'h00A1, 1'b0); send(16'h00A2, 1'b0); send(16'h00A3, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("s2_data", out_data, 128'h00A3_00A2_00A1);
    chk("s2_keep", {120'd0, out_keep}, 128'h07);
    chk("s2_lanes", {124'd0, lane_cnt}, 128'd0);
    repeat (2) @(negedge clk);
`ifdef WIDTH_PACK_STATS_EN
    chk("stat_words", {112'd0, stat_words}, 128'd2);
    chk("stat_partial", {112'd0, stat_partial}, 128'd1);
`endif

    // Back-pressure: 24 words offered, only 16 fit
    @(posedge clk); #1;
    out_ready = 1'b0; acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) send(16'h0100 + 16'(i), 1'b0);
      end
      begin
        for (int c = 0; c < 100 && acc_cnt < 16; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("bp_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_accepted", 128'(acc_cnt), 128'd16);
        chk("bp_lanes", {124'd0, lane_cnt}, 128'd8);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_ready_back", {127'd0, in_ready}, 128'd1);
      end
    join
    in_valid = 1'b0;
    for (int c = 0; c < 50 && sb_q.size() > 0; c++) @(negedge clk);
    chk("bp_drained", 128'(sb_q.size()), 128'd0);

    // Reset mid-fill
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i), 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    tb_rst = 1'b1;
    #1;
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_lanes", {124'd0, lane_cnt}, 128'd0);
    m_acc = '0; m_n = 0;
    #2 tb_rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("s4_data", out_data, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    chk("s4_keep", {120'd0, out_keep}, 128'hFF);
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(negedge clk);
    chk("final_drained", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/width_pack_16to128.md
Name: width_pack_16to128

Overview:
- Width packer for the opposite direction of the 128-bit-in / 16-bit-out async FIFO path.
- Gathers successive 16-bit words from a narrow producer (for example a FIFO read port at 16 bits) into 128-bit words.
- Presents each 128-bit word with a lane-valid mask on a valid/ready interface to the wide consumer.
- Supports early flush of a partial word. Single clock domain; sits on the read side of the narrow FIFO.

Parameters:
- IN_WIDTH, 16: narrow input word width.
- OUT_WIDTH, 128: wide output word width. Must be an integer multiple of IN_WIDTH. RATIO = OUT_WIDTH/IN_WIDTH = 8 is a derived localparam.
- MSB_FIRST, 0: lane fill order. 0 = first accepted word lands in [IN_WIDTH-1:0]. 1 = first accepted word lands in [OUT_WIDTH-1:OUT_WIDTH-IN_WIDTH].

Ports:
- clk  input  1  clock
- tb_rst  input  1  reset, asynchronous, active-high
- in_data  input  IN_WIDTH  narrow data
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies the accepted word as the final word of a partial group; forces flush
- in_ready  output  1  packer can accept in_data this cycle
- out_data  output  OUT_WIDTH  packed word
- out_keep  output  RATIO  per-lane valid mask, bit i = lane i (lane 0 = first accepted)
- out_valid  output  1  out_data/out_keep valid
- out_ready  input  1  consumer accepts the word
- lane_cnt  output  4  lanes currently held in the accumulator (0..8)

Behaviour:
- Reset values, while tb_rst is high and immediately after release:
  - out_valid=0, out_data=0, out_keep=0.
  - lane_cnt=0, in_ready=1, state FILL.
  - Accumulator is cleared.
- Handshake rules:
  - Input accept = in_valid && in_ready at the posedge.
  - Output transfer = out_valid && out_ready at the posedge.
  - in_valid without in_ready changes no state.
- Lane placement:
  - An accepted word is written to accumulator lane lane_cnt, then lane_cnt increments.
  - Lane position follows MSB_FIRST.
  - Unfilled lanes are zero.
- Completion: a word completes when the accepted word is lane 7, or when in_last=1 is accepted.
  - in_last on lane 7 is an ordinary full word.
- States:
  - FILL: in_ready=1. On completion:
    - If the output stage is empty, or is transferring at the same edge, the accumulator and keep move to out_data/out_keep, out_valid=1 from the next cycle, the accumulator clears, lane_cnt=0, and the state stays FILL.
    - Otherwise go to HOLD with lane_cnt=8 (or the partial count).
  - HOLD: in_ready=0. On an output transfer, the held word moves to the output stage at that edge, the accumulator clears, and the next state is FILL (in_ready=1 the following cycle).
- in_ready is registered; it is a function of state only.
- Latency: out_valid rises one cycle after the completing input accept.
- Throughput: with out_ready held high, sustained 1 input per cycle with no stalls, i.e. one output every 8 cycles.
- Buffering: at most 2 wide words held (output stage plus accumulator in HOLD).
- Ordering: output words leave in input order.
- out_data/out_keep hold stable while out_valid=1 and out_ready=0.
- out_keep:
  - All-ones (0xFF) for a full word.
  - For a partial flush of n lanes, the lower n bits are set, independent of MSB_FIRST.
- Reset mid-operation: any partial accumulator or pending output is discarded and all outputs return to reset values. No output transfer occurs on the reset edge.

Optional Feature:
- Macro: WIDTH_PACK_STATS_EN.
- Defined:
  - Adds output stat_words (16 bits): increments on every output transfer, wraps 0xFFFF→0.
  - Adds output stat_partial (16 bits): increments on each output transfer with out_keep != all-ones, wraps.
  - Both counters reset to 0.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Test Plan:
- Reset, then in_data=0x0000..0x0007 on 8 consecutive cycles, out_ready=1 → one cycle after the 8th accept:
  - out_valid=1, out_data=0x0007_0006_0005_0004_0003_0002_0001_0000, out_keep=0xFF.
  - in_ready stays 1 throughout.
- 3 words 0xA1,0xA2,0xA3 with in_last on the third → out_data=0x…0000_00A3_00A2_00A1 (upper lanes 0), out_keep=0x07, lane_cnt returns to 0.
- out_ready=0 while 24 words are offered continuously:
  - Exactly 16 are accepted; in_ready=0 after the 16th; out_data is stable.
  - Raise out_ready: words 0-7, 8-15, 16-23 emerge in order.
  - in_ready=1 the cycle after the first transfer.
- 5 words accepted, then a tb_rst pulse:
  - out_valid=0 and lane_cnt=0 immediately.
  - The next 8 words 0x10..0x17 form one clean word with out_keep=0xFF.
- MSB_FIRST=1, words 0x0000..0x0007 → out_data=0x0000_0001_0002_0003_0004_0005_0006_0007, out_keep=0xFF.
- With WIDTH_PACK_STATS_EN, run scenarios 1 and 2 → stat_words=2, stat_partial=1.
